// File: rtl/video_timing_ctrl.sv
// ----------------------------------------------------------------------------
// video_timing_ctrl
//
// Raster timing controller for the video pattern datapath. Two nested phase
// FSMs walk the horizontal (pixel) and vertical (line) raster through active,
// front porch, sync and back porch. The controller drives pixel coordinates
// to the pattern generator and sync/active qualifiers to the display stage.
// The FSMs hold the position that will be presented on the next enabled
// cycle. All outputs are registered and show that position one cycle after
// the enabled cycle.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   pixel_en     in   advance one pixel this cycle
//   x            out  pixel column, 0 outside the visible area
//   y            out  pixel row, 0 outside the visible area
//   active       out  x/y address a visible pixel
//   hsync        out  horizontal sync, SYNC_ACTIVE_LEVEL while asserted
//   vsync        out  vertical sync, SYNC_ACTIVE_LEVEL while asserted
//   frame_start  out  one-cycle pulse with pixel (0,0); present only when
//                     VIDEO_TIMING_CTRL_FRAME_START_EN is defined
//
// Optional feature macro: VIDEO_TIMING_CTRL_FRAME_START_EN
//
// Horizontal FSM (pixels)         Vertical FSM (lines)
//   state    | meaning              state    | meaning
//   H_ACTIVE | visible pixels       V_ACTIVE | visible lines
//   H_FRONT  | front porch          V_FRONT  | front porch
//   H_SYNC   | hsync pulse          V_SYNC   | vsync pulse
//   H_BACK   | back porch           V_BACK   | back porch
// ----------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC          = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC          = 2,
    parameter int VER_BACK_PORCH    = 33,
    parameter bit SYNC_ACTIVE_LEVEL = 1'b0,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pixel_en,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               active,
    output logic               hsync,
`ifdef VIDEO_TIMING_CTRL_FRAME_START_EN
    output logic               vsync,
    output logic               frame_start
`else
    output logic               vsync
`endif
);

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int H_MAX   = max4(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC, HOR_BACK_PORCH);
    localparam int V_MAX   = max4(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC, VER_BACK_PORCH);
    localparam int H_CNT_W = $clog2(H_MAX);
    localparam int V_CNT_W = $clog2(V_MAX);

    if (HOR_ACTIVE_PIXELS < 2 || VER_ACTIVE_PIXELS < 2 ||
        HOR_FRONT_PORCH < 1 || HOR_SYNC < 1 || HOR_BACK_PORCH < 1 ||
        VER_FRONT_PORCH < 1 || VER_SYNC < 1 || VER_BACK_PORCH < 1) begin : g_bad_params
        $error("video_timing_ctrl: active lengths must be >= 2 and porch/sync lengths >= 1");
    end

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_e;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_e;

    h_state_e           h_state_q, h_state_d;
    v_state_e           v_state_q, v_state_d;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               active_q, active_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;

    logic [H_CNT_W-1:0] h_last_cnt;
    logic [V_CNT_W-1:0] v_last_cnt;
    logic               h_last;
    logic               v_last;
    logic               line_end;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_state_q     <= H_ACTIVE;
            v_state_q     <= V_ACTIVE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE_LEVEL;
            vsync_q       <= ~SYNC_ACTIVE_LEVEL;
            frame_start_q <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        h_last_cnt = '0;
        case (h_state_q)
            H_ACTIVE: h_last_cnt = H_CNT_W'(HOR_ACTIVE_PIXELS - 1);
            H_FRONT:  h_last_cnt = H_CNT_W'(HOR_FRONT_PORCH - 1);
            H_SYNC:   h_last_cnt = H_CNT_W'(HOR_SYNC - 1);
            H_BACK:   h_last_cnt = H_CNT_W'(HOR_BACK_PORCH - 1);
            default:  h_last_cnt = '0;
        endcase

        v_last_cnt = '0;
        case (v_state_q)
            V_ACTIVE: v_last_cnt = V_CNT_W'(VER_ACTIVE_PIXELS - 1);
            V_FRONT:  v_last_cnt = V_CNT_W'(VER_FRONT_PORCH - 1);
            V_SYNC:   v_last_cnt = V_CNT_W'(VER_SYNC - 1);
            V_BACK:   v_last_cnt = V_CNT_W'(VER_BACK_PORCH - 1);
            default:  v_last_cnt = '0;
        endcase

        h_last   = (h_cnt_q == h_last_cnt);
        v_last   = (v_cnt_q == v_last_cnt);
        // The vertical FSM only moves on the enabled cycle that closes a line.
        line_end = pixel_en && (h_state_q == H_BACK) && h_last;

        h_state_d = h_state_q;
        h_cnt_d   = h_cnt_q;
        if (pixel_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                case (h_state_q)
                    H_ACTIVE: h_state_d = H_FRONT;
                    H_FRONT:  h_state_d = H_SYNC;
                    H_SYNC:   h_state_d = H_BACK;
                    H_BACK:   h_state_d = H_ACTIVE;
                    default:  h_state_d = H_ACTIVE;
                endcase
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        v_state_d = v_state_q;
        v_cnt_d   = v_cnt_q;
        if (line_end) begin
            if (v_last) begin
                v_cnt_d = '0;
                case (v_state_q)
                    V_ACTIVE: v_state_d = V_FRONT;
                    V_FRONT:  v_state_d = V_SYNC;
                    V_SYNC:   v_state_d = V_BACK;
                    V_BACK:   v_state_d = V_ACTIVE;
                    default:  v_state_d = V_ACTIVE;
                endcase
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: decode the position being consumed this cycle; the
    // registers hold their value while pixel_en is low.
    // ------------------------------------------------------------------
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (pixel_en) begin
            active_d = (h_state_q == H_ACTIVE) && (v_state_q == V_ACTIVE);
            // Counters never exceed the active length while in the active
            // phase, so the narrowing casts lose nothing when they are used.
            x_d      = active_d ? X_WIDTH'(h_cnt_q) : '0;
            y_d      = active_d ? Y_WIDTH'(v_cnt_q) : '0;
            hsync_d  = (h_state_q == H_SYNC) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            vsync_d  = (v_state_q == V_SYNC) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            frame_start_d = active_d && (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign active = active_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;

`ifdef VIDEO_TIMING_CTRL_FRAME_START_EN
    assign frame_start = frame_start_q;
`else
    // Feature disabled: the pulse register has no load and is trimmed.
    logic unused_frame_start;
    assign unused_frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
module tb_video_timing_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic pixel_en;

    always #5 clk = ~clk;

    // Timing sets: index 0 = tiny raster, index 1 = default VGA raster.
    // Order: HA, HF, HS, HB, VA, VF, VS, VB
    localparam int P [2][8] = '{'{4, 1, 2, 1, 3, 1, 1, 1},
                                '{640, 16, 96, 48, 480, 10, 2, 33}};

    logic [1:0] t_x;
    logic [1:0] t_y;
    logic       t_active, t_hsync, t_vsync, t_fs;
    logic [9:0] d_x;
    logic [8:0] d_y;
    logic       d_active, d_hsync, d_vsync, d_fs;

    video_timing_ctrl #(
        .HOR_ACTIVE_PIXELS(4), .HOR_FRONT_PORCH(1), .HOR_SYNC(2), .HOR_BACK_PORCH(1),
        .VER_ACTIVE_PIXELS(3), .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
        .SYNC_ACTIVE_LEVEL(1'b0)
    ) u_tiny (
        .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
        .x(t_x), .y(t_y), .active(t_active), .hsync(t_hsync),
`ifdef VIDEO_TIMING_CTRL_FRAME_START_EN
        .vsync(t_vsync), .frame_start(t_fs)
`else
        .vsync(t_vsync)
`endif
    );

    video_timing_ctrl u_dflt (
        .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
        .x(d_x), .y(d_y), .active(d_active), .hsync(d_hsync),
`ifdef VIDEO_TIMING_CTRL_FRAME_START_EN
        .vsync(d_vsync), .frame_start(d_fs)
`else
        .vsync(d_vsync)
`endif
    );

`ifndef VIDEO_TIMING_CTRL_FRAME_START_EN
    assign t_fs = 1'b0;
    assign d_fs = 1'b0;
`endif

    typedef struct {
        logic act;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic fs;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   n   [2];
    exp_t e   [2];

    // Reference: pixel index n within a frame -> what the display should see.
    function automatic exp_t model(input int k, input int idx);
        exp_t r;
        int ha, hf, hs, hb, va, vf, vs, vb, ht, hp, ln;
        ha = P[idx][0]; hf = P[idx][1]; hs = P[idx][2]; hb = P[idx][3];
        va = P[idx][4]; vf = P[idx][5]; vs = P[idx][6]; vb = P[idx][7];
        ht  = ha + hf + hs + hb;
        hp  = k % ht;
        ln  = k / ht;
        r.act = (hp < ha) && (ln < va);
        r.x   = r.act ? hp : 0;
        r.y   = r.act ? ln : 0;
        r.hs  = (hp >= ha + hf && hp < ha + hf + hs) ? 1'b0 : 1'b1;
        r.vs  = (ln >= va + vf && ln < va + vf + vs) ? 1'b0 : 1'b1;
        r.fs  = (k == 0);
        return r;
    endfunction

    function automatic int frame_len(input int idx);
        return (P[idx][0] + P[idx][1] + P[idx][2] + P[idx][3]) *
               (P[idx][4] + P[idx][5] + P[idx][6] + P[idx][7]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("tiny.active", 32'(t_active), 32'(e[0].act));
        chk("tiny.x",      32'(t_x),      e[0].x);
        chk("tiny.y",      32'(t_y),      e[0].y);
        chk("tiny.hsync",  32'(t_hsync),  32'(e[0].hs));
        chk("tiny.vsync",  32'(t_vsync),  32'(e[0].vs));
        chk("dflt.active", 32'(d_active), 32'(e[1].act));
        chk("dflt.x",      32'(d_x),      e[1].x);
        chk("dflt.y",      32'(d_y),      e[1].y);
        chk("dflt.hsync",  32'(d_hsync),  32'(e[1].hs));
        chk("dflt.vsync",  32'(d_vsync),  32'(e[1].vs));
`ifdef VIDEO_TIMING_CTRL_FRAME_START_EN
        chk("tiny.frame_start", 32'(t_fs), 32'(e[0].fs));
        chk("dflt.frame_start", 32'(d_fs), 32'(e[1].fs));
`endif
    endtask

    // Apply inputs, take one clock edge, advance the reference, then check.
    task automatic step(input logic rst, input logic pen);
        rst_n    = rst;
        pixel_en = pen;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                n[d] = 0;
                e[d] = '{act: 1'b0, x: 0, y: 0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
            end else if (pen) begin
                e[d] = model(n[d], d);
                n[d] = (n[d] + 1) % frame_len(d);
            end else begin
                e[d].fs = 1'b0;
            end
        end
        #1;
        compare_all();
    endtask

    int cnt_act, cnt_hs, cnt_vs;

    initial begin
        rst_n    = 1'b0;
        pixel_en = 1'b1;

        // Reset held with pixel_en high
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

        // Stall at x=2 of the first line
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("stall.x_before", 32'(t_x), 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("stall.x_frozen", 32'(t_x), 2);
        end
        step(1'b1, 1'b1);
        chk("stall.x_after", 32'(t_x), 3);

        // Reset in the middle of line 1 (y=1, x=1)
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        chk("midrst.pre_y", 32'(t_y), 1);
        chk("midrst.pre_x", 32'(t_x), 1);
        step(1'b0, 1'b1);
        chk("midrst.active", 32'(t_active), 0);
        chk("midrst.hsync", 32'(t_hsync), 1);
        step(1'b1, 1'b1);
        chk("midrst.first_active", 32'(t_active), 1);
        chk("midrst.first_x", 32'(t_x), 0);

        // One full tiny frame from the reset release, then the wrap
        cnt_act = 32'(t_active);
        cnt_hs  = (t_hsync == 1'b0) ? 1 : 0;
        cnt_vs  = (t_vsync == 1'b0) ? 1 : 0;
        for (int i = 1; i < 48; i++) begin
            step(1'b1, 1'b1);
            cnt_act += t_active ? 1 : 0;
            cnt_hs  += t_hsync ? 0 : 1;
            cnt_vs  += t_vsync ? 0 : 1;
        end
        chk("frame.active_cycles", 32'(cnt_act), 12);
        chk("frame.hsync_low_cycles", 32'(cnt_hs), 12);
        chk("frame.vsync_low_cycles", 32'(cnt_vs), 8);
        step(1'b1, 1'b1);
        chk("frame.wrap_active", 32'(t_active), 1);
        chk("frame.wrap_x", 32'(t_x), 0);
        chk("frame.wrap_y", 32'(t_y), 0);

        // One full default-timing line
        step(1'b0, 1'b1);
        cnt_act = 0;
        cnt_hs  = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b1);
            cnt_act += d_active ? 1 : 0;
            cnt_hs  += d_hsync ? 0 : 1;
        end
        chk("dline.active_cycles", 32'(cnt_act), 640);
        chk("dline.hsync_low_cycles", 32'(cnt_hs), 96);
        step(1'b1, 1'b1);
        chk("dline.next_y", 32'(d_y), 1);
        chk("dline.next_x", 32'(d_x), 0);

        // Randomized enables with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Raster timing controller that sequences the video pattern datapath.
- Walks horizontal and vertical counters through the active, front porch, sync and back porch phases.
- Drives pixel coordinates x/y into the pattern generator and produces hsync, vsync and active for the display output stage.
- All outputs are registered; one pixel per clock when pixel_en is high.

Parameters:
- HOR_ACTIVE_PIXELS, 640: visible pixels per line.
- HOR_FRONT_PORCH, 16: pixels from end of active to start of hsync.
- HOR_SYNC, 96: hsync pulse width in pixels.
- HOR_BACK_PORCH, 48: pixels from end of hsync to start of active.
- VER_ACTIVE_PIXELS, 480: visible lines per frame.
- VER_FRONT_PORCH, 10: lines.
- VER_SYNC, 2: lines.
- VER_BACK_PORCH, 33: lines.
- SYNC_ACTIVE_LEVEL, 0: level of hsync/vsync while asserted (0 = active-low).

Ports:
- clk  input  1  system/pixel clock.
- rst_n  input  1  synchronous active-low reset.
- pixel_en  input  1  advance one pixel this cycle.
- x  output  X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)  pixel column; 0 outside active.
- y  output  Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)  pixel row; 0 outside active.
- active  output  1  x/y are a visible pixel.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.

Behaviour:
- Clocking/reset: one clock, reset synchronous and active-low; all state sampled on posedge clk.
- Reset values while rst_n low: x=0, y=0, active=0, hsync=vsync=~SYNC_ACTIVE_LEVEL, h_state=v_state=H_ACTIVE/V_ACTIVE, h_cnt=v_cnt=0.
- Horizontal FSM: H_ACTIVE → H_FRONT → H_SYNC → H_BACK → H_ACTIVE.
  - Each phase lasts its parameter length in pixels.
  - h_cnt counts within the phase, resets to 0 on every phase change.
  - Counter width covers the largest horizontal parameter.
- Vertical FSM: V_ACTIVE → V_FRONT → V_SYNC → V_BACK → V_ACTIVE, same rules counted in lines.
  - Steps only on the pixel_en cycle that ends H_BACK (line end).
- Frame wrap: last pixel of H_BACK on last line of V_BACK → next position is (H_ACTIVE, 0) / (V_ACTIVE, 0).
- Frame length: (HA+HF+HS+HB) × (VA+VF+VS+VB) enabled cycles; 800×525 with defaults.
- pixel_en low: counters, states and all outputs hold their values.
- Output latency: 1 cycle. On the cycle after a pixel_en-high cycle at position P, outputs reflect P:
  - active = (h_state==H_ACTIVE && v_state==V_ACTIVE).
  - x = h_cnt when active else 0; y = v_cnt when active else 0.
  - hsync = SYNC_ACTIVE_LEVEL iff h_state==H_SYNC, independent of the vertical phase.
  - vsync = SYNC_ACTIVE_LEVEL iff v_state==V_SYNC; changes only at line boundaries, aligned with the first pixel of a line.
- First output after reset: first pixel_en-high cycle after rst_n returns high presents pixel (0,0); outputs show it one cycle later.
- Reset mid-frame: the next clock returns to the reset values; no partial line or frame is completed.
- Parameter constraints: every porch/sync value ≥1; HOR/VER_ACTIVE_PIXELS ≥2. Elaboration error otherwise.

Optional Feature:
- Macro: VIDEO_TIMING_CTRL_FRAME_START_EN.
- Defined: adds output frame_start (1 bit).
  - Pulses high for exactly one cycle, aligned with the output cycle presenting pixel (0,0) with active=1.
  - 0 in reset and while pixel_en holds.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with pixel_en=1 → x=0, y=0, active=0, hsync=vsync=1 (defaults) on every cycle.
- Line timing: tiny params HA=4, HF=1, HS=2, HB=1, VA=3, VF=1, VS=1, VB=1, pixel_en=1:
  - active high 4 cycles with x=0,1,2,3, then low 4 cycles.
  - hsync low exactly output cycles 5–6 of each 8-cycle line.
- Frame timing, same params:
  - frame = 48 cycles; vsync low for line 4 (cycles 32–39, zero-based).
  - y=0,1,2 on the active lines; next frame restarts at (0,0) on cycle 48.
- Stall: drop pixel_en for 3 cycles while x=2 → outputs frozen at x=2 for 3 extra cycles, then x=3.
- Reset mid-frame: assert rst_n=0 at line 2, x=1 → next cycle reset values; first enabled cycle after release gives (0,0).
- Default params: count 800 enabled cycles per line, 525 lines per frame, 307200 active cycles per frame; with VIDEO_TIMING_CTRL_FRAME_START_EN, exactly one frame_start per 420000 enabled cycles.
